// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and parity helpers for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit a correct transmitter sends, given the XOR of the data bits.
  function automatic logic f_exp_parity(input logic i_data_xor, input logic i_par_typ);
    return i_data_xor ^ (i_par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - signal bundle between the frame controller, counter/sampler and consumer
interface uart_rx_fsm_if #(
  parameter int PRESCALE   = 32,
  parameter int DATA_WIDTH = 8
);
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [PW-1:0]         prescale;
  logic [PW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  sampled_bit;
  logic                  cnt_en;
  logic                  dat_samp_en;
  logic [DATA_WIDTH-1:0] p_dat;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, par_en, par_typ, prescale, edge_cnt, bit_cnt, sampled_bit,
    input  cnt_en, dat_samp_en, p_dat, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale, edge_cnt, bit_cnt, sampled_bit,
    output cnt_en, dat_samp_en, p_dat, data_valid, par_err, stp_err
  );

endinterface

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - LSB-first shift register with parallel capture of the received word
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_shift_en,
  input  logic                  i_load_en,
  input  logic                  i_sampled_bit,
  output logic [DATA_WIDTH-1:0] o_shreg,
  output logic [DATA_WIDTH-1:0] o_p_dat
);

  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_p_dat;

  // Shifting in at the top means the first bit received ends up in the LSB.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shreg <= '0;
      r_p_dat <= '0;
    end else begin
      if (i_shift_en) begin
        r_shreg <= {i_sampled_bit, r_shreg[DATA_WIDTH-1:1]};
      end
      if (i_load_en) begin
        r_p_dat <= r_shreg;
      end
    end
  end

  assign o_shreg = r_shreg;
  assign o_p_dat = r_p_dat;

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame controller: start/data/parity/stop sequencing and checks
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_fsm_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  state_t                r_state;
  state_t                w_next;
  logic                  w_bit_end;
  logic                  w_shift_en;
  logic                  w_load_en;
  logic [DATA_WIDTH-1:0] w_shreg;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  assign w_bit_end = (bus.edge_cnt == (bus.prescale - PW'(1)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_load_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.rx_in) begin
          w_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_next = bus.sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_en = 1'b1;
          if (bus.bit_cnt == BW'(DATA_WIDTH)) begin
            w_next = bus.par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_next = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_next    = IDLE;
          w_load_en = bus.sampled_bit && !r_par_err;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Flags are cleared only when a new frame begins so the consumer can read them afterwards.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= w_load_en;
      case (r_state)
        IDLE: begin
          if (!bus.rx_in) begin
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_par_err <= (bus.sampled_bit != f_exp_parity(^w_shreg, bus.par_typ));
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_stp_err <= ~bus.sampled_bit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  uart_rx_deser #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_deser (
    .CLK           (CLK),
    .RST           (RST),
    .i_shift_en    (w_shift_en),
    .i_load_en     (w_load_en),
    .i_sampled_bit (bus.sampled_bit),
    .o_shreg       (w_shreg),
    .o_p_dat       (bus.p_dat)
  );

  assign bus.cnt_en      = (r_state != IDLE);
  assign bus.dat_samp_en = (r_state != IDLE);
  assign bus.data_valid  = r_data_valid;
  assign bus.par_err     = r_par_err;
  assign bus.stp_err     = r_stp_err;

endmodule
